// File: rtl/quad_shift_pipe.sv
// quad_shift_pipe: LAT-stage quadword shift/rotate unit; SHUFB (op 5) built only when QSP_SHUFB_EN is defined.
module quad_shift_pipe #(
  parameter int W   = 128,
  parameter int LAT = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         stall,
  input  logic         in_valid,
  input  logic [2:0]   in_op,
  input  logic [6:0]   in_rt,
  input  logic [W-1:0] ra,
  input  logic [W-1:0] rb,
  input  logic [W-1:0] rc,
  output logic         in_ready,
  output logic         out_valid,
  output logic [6:0]   out_rt,
  output logic [W-1:0] out_data
);
  localparam int NB = W / 8;
  localparam int CB = $clog2(NB);
  logic [2:0]     b3;
  logic [CB:0]    byc, m;
  logic [CB-1:0]  byr;
  logic [7:0]     mneg;
  logic [2*W-1:0] rot_bit, rot_byte;
  logic [W-1:0]   shlqbi, shlqby, rotqbi, rotqby, rotqmby, shufb, result;
  logic           take;
  logic           v [LAT];
  logic [6:0]     t [LAT];
  logic [W-1:0]   d [LAT];
  assign b3       = rb[2:0];
  assign byc      = rb[CB:0];
  assign byr      = rb[CB-1:0];
  assign mneg     = 8'd0 - rb[7:0];
  assign m        = mneg[CB:0];
  assign shlqbi   = ra << b3;
  // counts are below 2*NB, so the top count bit alone flags a shift of NB bytes or more
  assign shlqby   = byc[CB] ? '0 : ra << {byc, 3'b000};
  assign rot_bit  = {ra, ra} << b3;
  assign rot_byte = {ra, ra} << {byr, 3'b000};
  assign rotqbi   = rot_bit[2*W-1:W];
  assign rotqby   = rot_byte[2*W-1:W];
  assign rotqmby  = m[CB] ? '0 : ra >> {m, 3'b000};
`ifdef QSP_SHUFB_EN
  logic [2*W-1:0] cat;
  assign cat = {ra, rb};
  always_comb begin
    shufb = '0;
    for (int i = 0; i < NB; i++) begin
      shufb[W-1-8*i -: 8] = rc[W-1-8*i -: 2] == 2'b10 ? 8'h00 :
                            rc[W-1-8*i -: 3] == 3'b110 ? 8'hFF :
                            rc[W-1-8*i -: 3] == 3'b111 ? 8'h80 :
                            cat[2*W-1-8*int'(rc[W-8-8*i +: CB+1]) -: 8];
    end
  end
`else
  logic unused_ok;
  assign unused_ok = ^{rc, rb[W-1:8]};
  assign shufb     = '0;
`endif
  assign result = in_op == 3'd0 ? shlqbi  :
                  in_op == 3'd1 ? shlqby  :
                  in_op == 3'd2 ? rotqbi  :
                  in_op == 3'd3 ? rotqby  :
                  in_op == 3'd4 ? rotqmby :
                  in_op == 3'd5 ? shufb   : '0;
  assign take      = in_valid & ~stall & ~flush;
  assign in_ready  = ~stall;
  assign out_valid = v[LAT-1];
  assign out_rt    = t[LAT-1];
  assign out_data  = d[LAT-1];
  always_ff @(posedge clk or posedge reset) begin
    if (reset || flush) begin
      for (int i = 0; i < LAT; i++) begin
        v[i] <= 1'b0;
        t[i] <= '0;
        d[i] <= '0;
      end
    end else if (!stall) begin
      v[0] <= take;
      t[0] <= take ? in_rt : '0;
      d[0] <= take ? result : '0;
      for (int i = 1; i < LAT; i++) begin
        v[i] <= v[i-1];
        t[i] <= t[i-1];
        d[i] <= d[i-1];
      end
    end
  end
endmodule
